// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants, ALU operation codes and the ID/EX payload.
package riscv_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned RF_AW = 5;
   localparam int unsigned OPW   = 4;

   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI   = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC = 7'b0010111;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   localparam logic [OPW-1:0] ALU_ADD   = 4'd0;
   localparam logic [OPW-1:0] ALU_SUB   = 4'd1;
   localparam logic [OPW-1:0] ALU_AND   = 4'd2;
   localparam logic [OPW-1:0] ALU_SLT   = 4'd3;
   localparam logic [OPW-1:0] ALU_SLTU  = 4'd4;
   localparam logic [OPW-1:0] ALU_OR    = 4'd5;
   localparam logic [OPW-1:0] ALU_SLL   = 4'd6;
   localparam logic [OPW-1:0] ALU_SRA   = 4'd7;
   localparam logic [OPW-1:0] ALU_XOR   = 4'd8;
   localparam logic [OPW-1:0] ALU_SRL   = 4'd9;
   localparam logic [OPW-1:0] ALU_PASSB = 4'd10;

   typedef struct packed {
      logic [XLEN-1:0]  pc;
      logic [XLEN-1:0]  a;
      logic [XLEN-1:0]  b;
      logic [OPW-1:0]   aluop;
      logic [RF_AW-1:0] rd;
      logic             wb_en;
      logic             illegal;
   } id_ex_t;

endpackage

// File: rtl/riscv_alu_decode.sv
// Combinational decode of an ALU-class RV32I instruction into op, operands and writeback info.
module riscv_alu_decode
   import riscv_pkg::*;
(
   input  logic [31:0]   instr,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   output id_ex_t        dec_c
);

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [6:0]      funct7;
   logic [4:0]      rd;
   logic [XLEN-1:0] imm_i;
   logic [XLEN-1:0] imm_u;
   logic [XLEN-1:0] shamt;
   logic [OPW-1:0]  op;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic            legal;

   assign opcode = instr[6:0];
   assign rd     = instr[11:7];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];
   assign imm_i  = XLEN'($signed(instr[31:20]));
   assign imm_u  = XLEN'($signed({instr[31:12], 12'b0}));
   assign shamt  = XLEN'(instr[24:20]);

   always_comb begin
      op    = ALU_ADD;
      a     = '0;
      b     = '0;
      legal = 1'b1;
      case (opcode)
         OPC_OP: begin
            a = rs1_data;
            b = rs2_data;
            if (funct7 != F7_BASE && funct7 != F7_ALT) legal = 1'b0;
            else if (funct7[5] && funct3 != F3_ADD && funct3 != F3_SR) legal = 1'b0;
            case (funct3)
               F3_ADD:  op = funct7[5] ? ALU_SUB : ALU_ADD;
               F3_SLL:  op = ALU_SLL;
               F3_SLT:  op = ALU_SLT;
               F3_SLTU: op = ALU_SLTU;
               F3_XOR:  op = ALU_XOR;
               F3_SR:   op = funct7[5] ? ALU_SRA : ALU_SRL;
               F3_OR:   op = ALU_OR;
               default: op = ALU_AND;
            endcase
         end
         OPC_OPIMM: begin
            a = rs1_data;
            b = imm_i;
            case (funct3)
               F3_ADD:  op = ALU_ADD;
               F3_SLL: begin
                  op = ALU_SLL;
                  b  = shamt;
                  if (funct7 != F7_BASE) legal = 1'b0;
               end
               F3_SLT:  op = ALU_SLT;
               F3_SLTU: op = ALU_SLTU;
               F3_XOR:  op = ALU_XOR;
               F3_SR: begin
                  op = funct7[5] ? ALU_SRA : ALU_SRL;
                  b  = shamt;
                  if (funct7 != F7_BASE && funct7 != F7_ALT) legal = 1'b0;
               end
               F3_OR:   op = ALU_OR;
               default: op = ALU_AND;
            endcase
         end
         OPC_LUI: begin
            op = ALU_PASSB;
            b  = imm_u;
         end
         OPC_AUIPC: begin
            a = pc;
            b = imm_u;
         end
         default: legal = 1'b0;
      endcase
      // Anything illegal is issued as a harmless ADD 0,0 and trapped downstream.
      if (!legal) begin
         op = ALU_ADD;
         a  = '0;
         b  = '0;
      end
   end

   always_comb begin
      dec_c         = '0;
      dec_c.pc      = pc;
      dec_c.a       = a;
      dec_c.b       = b;
      dec_c.aluop   = op;
      dec_c.rd      = rd;
      dec_c.wb_en   = legal && (rd != 5'd0);
      dec_c.illegal = !legal;
   end

endmodule

// File: rtl/riscv_id_ex_stage.sv
// ID/EX stage: decodes ALU-class instructions and holds them in a valid/ready pipeline register.
module riscv_id_ex_stage
   import riscv_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [XLEN-1:0]  in_pc,
   input  logic [XLEN-1:0]  in_rs1_data,
   input  logic [XLEN-1:0]  in_rs2_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  alu_Ain,
   output logic [XLEN-1:0]  alu_Bin,
   output logic [OPW-1:0]   aluop,
   output logic [RF_AW-1:0] out_rd,
   output logic             out_wb_en,
   output logic [XLEN-1:0]  out_pc,
   output logic             out_illegal
);

   id_ex_t dec_c;
   id_ex_t q;
   logic   load_c;

   riscv_alu_decode u_dec (
      .instr    (in_instr),
      .pc       (in_pc),
      .rs1_data (in_rs1_data),
      .rs2_data (in_rs2_data),
      .dec_c    (dec_c)
   );

   assign in_ready = !out_valid || out_ready;
   assign load_c   = in_valid && in_ready;

   // Flush beats load; a drained beat with nothing behind it empties the register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         q         <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
         q.wb_en   <= 1'b0;
      end else if (load_c) begin
         out_valid <= 1'b1;
         q         <= dec_c;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   assign alu_Ain     = q.a;
   assign alu_Bin     = q.b;
   assign aluop       = q.aluop;
   assign out_rd      = q.rd;
   assign out_wb_en   = q.wb_en;
   assign out_pc      = q.pc;
   assign out_illegal = q.illegal;

endmodule

// File: tb/tb_riscv_id_ex_stage.sv
// Directed table-driven bench for the ID/EX stage plus stall, flush and reset sequences.
module tb_riscv_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic [31:0] in_rs1_data;
   logic [31:0] in_rs2_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] alu_Ain;
   logic [31:0] alu_Bin;
   logic [3:0]  aluop;
   logic [4:0]  out_rd;
   logic        out_wb_en;
   logic [31:0] out_pc;
   logic        out_illegal;

   int passed = 0;
   int total  = 0;

   riscv_id_ex_stage dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_instr    (in_instr),
      .in_pc       (in_pc),
      .in_rs1_data (in_rs1_data),
      .in_rs2_data (in_rs2_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .alu_Ain     (alu_Ain),
      .alu_Bin     (alu_Bin),
      .aluop       (aluop),
      .out_rd      (out_rd),
      .out_wb_en   (out_wb_en),
      .out_pc      (out_pc),
      .out_illegal (out_illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic        wb;
      logic        ill;
   } vec_t;

   vec_t vecs[17];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      else passed++;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                        input logic [31:0] rs1, input logic [31:0] rs2);
      in_valid    = 1'b1;
      in_instr    = instr;
      in_pc       = pc;
      in_rs1_data = rs1;
      in_rs2_data = rs2;
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_valid"},   32'(out_valid),   32'd0);
      check({tag, "_ain"},     alu_Ain,          32'd0);
      check({tag, "_bin"},     alu_Bin,          32'd0);
      check({tag, "_aluop"},   32'(aluop),       32'd0);
      check({tag, "_rd"},      32'(out_rd),      32'd0);
      check({tag, "_wb_en"},   32'(out_wb_en),   32'd0);
      check({tag, "_pc"},      out_pc,           32'd0);
      check({tag, "_illegal"}, 32'(out_illegal), 32'd0);
      check({tag, "_in_ready"}, 32'(in_ready),   32'd1);
   endtask

   initial begin
      vecs[0]  = '{"addi",       32'h00500093, 32'h0000_0000, 32'd0,         32'd0, 4'd0,  32'd0,         32'd5,         5'd1,  1'b1, 1'b0};
      vecs[1]  = '{"sub",        32'h402081B3, 32'h0000_0004, 32'd7,         32'd6, 4'd1,  32'd7,         32'd6,         5'd3,  1'b1, 1'b0};
      vecs[2]  = '{"srai",       32'h4030D213, 32'h0000_0008, 32'h8000_0000, 32'd0, 4'd7,  32'h8000_0000, 32'd3,         5'd4,  1'b1, 1'b0};
      vecs[3]  = '{"lui",        32'h123452B7, 32'h0000_000C, 32'hDEAD_BEEF, 32'd1, 4'd10, 32'd0,         32'h1234_5000, 5'd5,  1'b1, 1'b0};
      vecs[4]  = '{"auipc",      32'h00001317, 32'h0000_0100, 32'd9,         32'd9, 4'd0,  32'h0000_0100, 32'h0000_1000, 5'd6,  1'b1, 1'b0};
      vecs[5]  = '{"bad_opc",    32'h0000007F, 32'h0000_0104, 32'd3,         32'd4, 4'd0,  32'd0,         32'd0,         5'd0,  1'b0, 1'b1};
      vecs[6]  = '{"add_x0",     32'h00208033, 32'h0000_0108, 32'd1,         32'd2, 4'd0,  32'd1,         32'd2,         5'd0,  1'b0, 1'b0};
      vecs[7]  = '{"addi_neg",   32'hFFF08393, 32'h0000_010C, 32'd10,        32'd0, 4'd0,  32'd10,        32'hFFFF_FFFF, 5'd7,  1'b1, 1'b0};
      vecs[8]  = '{"or",         32'h0020E433, 32'h0000_0110, 32'h0F0F_0000, 32'h00F0, 4'd5, 32'h0F0F_0000, 32'h0000_00F0, 5'd8,  1'b1, 1'b0};
      vecs[9]  = '{"sltu",       32'h0020B4B3, 32'h0000_0114, 32'd5,         32'd6, 4'd4,  32'd5,         32'd6,         5'd9,  1'b1, 1'b0};
      vecs[10] = '{"slli31",     32'h01F09513, 32'h0000_0118, 32'd1,         32'd0, 4'd6,  32'd1,         32'd31,        5'd10, 1'b1, 1'b0};
      vecs[11] = '{"or_f7alt",   32'h4020E433, 32'h0000_011C, 32'd1,         32'd2, 4'd0,  32'd0,         32'd0,         5'd8,  1'b0, 1'b1};
      vecs[12] = '{"slti_min",   32'h8000A593, 32'h0000_0120, 32'd3,         32'd0, 4'd3,  32'd3,         32'hFFFF_F800, 5'd11, 1'b1, 1'b0};
      vecs[13] = '{"slli_f7alt", 32'h40109513, 32'h0000_0124, 32'd3,         32'd0, 4'd0,  32'd0,         32'd0,         5'd10, 1'b0, 1'b1};
      vecs[14] = '{"xori_max",   32'h7FF0C613, 32'h0000_0128, 32'd1,         32'd0, 4'd8,  32'd1,         32'h0000_07FF, 5'd12, 1'b1, 1'b0};
      vecs[15] = '{"srl",        32'h0020D6B3, 32'h0000_012C, 32'h80,        32'd4, 4'd9,  32'h80,        32'd4,         5'd13, 1'b1, 1'b0};
      vecs[16] = '{"and",        32'h0020F733, 32'h0000_0130, 32'hFF,        32'h0F, 4'd2, 32'hFF,        32'h0F,        5'd14, 1'b1, 1'b0};

      rst_n       = 1'b0;
      flush       = 1'b0;
      in_valid    = 1'b0;
      out_ready   = 1'b1;
      in_instr    = '0;
      in_pc       = '0;
      in_rs1_data = '0;
      in_rs2_data = '0;
      #12;
      check_zero_outputs("reset");
      rst_n = 1'b1;
      step();

      // Back-to-back issue with downstream always ready.
      for (int i = 0; i < 17; i++) begin
         drive(vecs[i].instr, vecs[i].pc, vecs[i].rs1, vecs[i].rs2);
         step();
         check({vecs[i].name, "_valid"},   32'(out_valid),   32'd1);
         check({vecs[i].name, "_aluop"},   32'(aluop),       32'(vecs[i].op));
         check({vecs[i].name, "_ain"},     alu_Ain,          vecs[i].a);
         check({vecs[i].name, "_bin"},     alu_Bin,          vecs[i].b);
         check({vecs[i].name, "_rd"},      32'(out_rd),      32'(vecs[i].rd));
         check({vecs[i].name, "_wb_en"},   32'(out_wb_en),   32'(vecs[i].wb));
         check({vecs[i].name, "_illegal"}, 32'(out_illegal), 32'(vecs[i].ill));
         check({vecs[i].name, "_pc"},      out_pc,           vecs[i].pc);
      end
      in_valid = 1'b0;
      step();
      check("drain_valid", 32'(out_valid), 32'd0);

      // Stall: second beat waits until out_ready returns.
      out_ready = 1'b0;
      drive(32'h00500093, 32'h200, 32'd0, 32'd0);
      step();
      check("stall_first_valid", 32'(out_valid), 32'd1);
      check("stall_in_ready",    32'(in_ready),  32'd0);
      drive(32'h402081B3, 32'h204, 32'd7, 32'd6);
      step();
      check("stall_hold_aluop", 32'(aluop),   32'd0);
      check("stall_hold_bin",   alu_Bin,      32'd5);
      check("stall_hold_pc",    out_pc,       32'h200);
      check("stall_hold_ready", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      #1;
      check("unstall_in_ready", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      check("second_valid", 32'(out_valid), 32'd1);
      check("second_aluop", 32'(aluop),     32'd1);
      check("second_ain",   alu_Ain,        32'd7);
      check("second_pc",    out_pc,         32'h204);
      step();
      check("second_drain", 32'(out_valid), 32'd0);

      // Flush while full and stalled, with a new beat offered.
      out_ready = 1'b0;
      drive(32'h00500093, 32'h300, 32'd0, 32'd0);
      step();
      check("pre_flush_wb", 32'(out_wb_en), 32'd1);
      flush = 1'b1;
      drive(32'h402081B3, 32'h304, 32'd7, 32'd6);
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      check("flush_valid",    32'(out_valid), 32'd0);
      check("flush_wb_en",    32'(out_wb_en), 32'd0);
      check("flush_in_ready", 32'(in_ready),  32'd1);
      check("flush_no_load",  32'(aluop),     32'd0);
      step();
      check("post_flush_valid", 32'(out_valid), 32'd0);

      // Asynchronous reset in the middle of a stall.
      drive(32'h402081B3, 32'h400, 32'd7, 32'd6);
      step();
      check("mid_stall_valid", 32'(out_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_zero_outputs("async_rst");
      in_valid = 1'b0;
      #3;
      rst_n = 1'b1;
      step();
      check("rst_release_ready", 32'(in_ready),  32'd1);
      check("rst_release_valid", 32'(out_valid), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
